// File: rtl/face_classifier_sdiv_seq.sv
// Sequential signed restoring divider (truncating, C-style) with valid/ready in and held result out.
// Optional macro FACE_CLASSIFIER_SDIV_DBZ_SAT_EN selects saturating divide-by-zero results.
module face_classifier_sdiv_seq #(
  parameter int unsigned WIDTH = 13
) (
  input  logic             ap_clk,
  input  logic             ap_rst,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StDiv, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] count_q, count_d;
  logic [WIDTH:0]  dvd_q, dvd_d, dvs_q, dvs_d, rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic            qsign_q, qsign_d, rsign_q, rsign_d, zero_q, zero_d;
  logic [WIDTH-1:0] quotient_d, remainder_d;
  logic            dbz_d;

  logic [WIDTH:0]   dividend_ext, divisor_ext, shifted, rem_step;
  logic [WIDTH+1:0] diff;
  logic             qbit;
  logic [WIDTH-1:0] quo_step;
  logic             unused_bits;

  assign dividend_ext = {dividend[WIDTH-1], dividend};
  assign divisor_ext  = {divisor[WIDTH-1], divisor};

  // One restoring step; partial remainder never exceeds WIDTH bits, so its top bit is spare.
  always_comb begin
    shifted  = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
    diff     = {1'b0, shifted} - {1'b0, dvs_q};
    qbit     = ~diff[WIDTH+1];
    rem_step = qbit ? diff[WIDTH:0] : shifted;
    quo_step = {quo_q[WIDTH-2:0], qbit};
  end

  assign unused_bits = ^{dvd_q[WIDTH], rem_q[WIDTH]};

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    qsign_d     = qsign_q;
    rsign_d     = rsign_q;
    zero_d      = zero_q;
    quotient_d  = quotient;
    remainder_d = remainder;
    dbz_d       = div_by_zero;
    unique case (state_q)
      StIdle: begin
        if (din_valid) begin
          dvd_d   = dividend[WIDTH-1] ? -dividend_ext : dividend_ext;
          dvs_d   = divisor[WIDTH-1] ? -divisor_ext : divisor_ext;
          qsign_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
          rsign_d = dividend[WIDTH-1];
          zero_d  = (divisor == '0);
          rem_d   = '0;
          quo_d   = '0;
          count_d = '0;
          state_d = StDiv;
        end
      end
      StDiv: begin
        rem_d   = rem_step;
        quo_d   = quo_step;
        dvd_d   = {dvd_q[WIDTH-1:0], 1'b0};
        count_d = count_q + CntW'(1);
        if (count_q == CntW'(WIDTH - 1)) begin
          state_d     = StDone;
          dbz_d       = zero_q;
          quotient_d  = qsign_q ? -quo_step : quo_step;
          remainder_d = rsign_q ? -rem_step[WIDTH-1:0] : rem_step[WIDTH-1:0];
          if (zero_q) begin
`ifdef FACE_CLASSIFIER_SDIV_DBZ_SAT_EN
            quotient_d  = rsign_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
            remainder_d = '0;
`else
            // Raw restoring result: all-ones quotient, remainder equals the dividend.
            quotient_d  = '1;
`endif
          end
        end
      end
      StDone: begin
        if (dout_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q     <= StIdle;
      count_q     <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      qsign_q     <= 1'b0;
      rsign_q     <= 1'b0;
      zero_q      <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      qsign_q     <= qsign_d;
      rsign_q     <= rsign_d;
      zero_q      <= zero_d;
      quotient    <= quotient_d;
      remainder   <= remainder_d;
      div_by_zero <= dbz_d;
    end
  end

  assign din_ready  = (state_q == StIdle);
  assign dout_valid = (state_q == StDone);

endmodule

// File: tb/tb_face_classifier_sdiv_seq.sv
// Scoreboard bench for face_classifier_sdiv_seq: driver pushes expected results, monitor pops on consume.
module tb_face_classifier_sdiv_seq;

  localparam int W = 13;

  logic         ap_clk = 1'b0;
  logic         ap_rst = 1'b1;
  logic         din_valid = 1'b0;
  logic         din_ready;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         dout_valid;
  logic         dout_ready = 1'b1;
  logic [W-1:0] quotient, remainder;
  logic         div_by_zero;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  face_classifier_sdiv_seq #(.WIDTH(W)) dut (
    .ap_clk     (ap_clk),
    .ap_rst     (ap_rst),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 ap_clk = ~ap_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: act=%0d req=%0d", name, act, req);
    end
  endtask

  // Monitor: compares each consumed result against the oldest expectation.
  always @(negedge ap_clk) begin
    if (!ap_rst && dout_valid && dout_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: act q=%0d r=%0d req none",
                 $signed(quotient), $signed(remainder));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.dbz) begin
          errors++;
          $display("FAIL result: act q=%0d r=%0d dbz=%0b req q=%0d r=%0d dbz=%0b",
                   $signed(quotient), $signed(remainder), div_by_zero,
                   $signed(e.q), $signed(e.r), e.dbz);
        end
      end
    end
  end

  // Presents operands until accepted; returns just after the accept edge.
  task automatic start(input int a, input int b);
    int n = 0;
    while (!din_ready && n < 50) begin
      @(posedge ap_clk); #1; n++;
    end
    check("din_ready_before_accept", int'(din_ready), 1);
    din_valid = 1'b1;
    dividend  = W'(a);
    divisor   = W'(b);
    @(posedge ap_clk); #1;
    din_valid = 1'b0;
    dividend  = W'($urandom);
    divisor   = W'($urandom);
  endtask

  task automatic do_op(input int a, input int b, input int eq, input int er, input bit edbz);
    int n = 0;
    exp_q.push_back('{q: W'(eq), r: W'(er), dbz: edbz});
    start(a, b);
    while (!dout_valid && n < 40) begin
      @(posedge ap_clk); #1; n++;
    end
    check("latency", n, W);
    if (dout_ready) begin
      @(posedge ap_clk); #1;
      check("din_ready_after_consume", int'(din_ready), 1);
    end
  endtask

  initial begin
    repeat (2) @(posedge ap_clk);
    #1;
    check("rst_din_ready", int'(din_ready), 1);
    check("rst_dout_valid", int'(dout_valid), 0);
    check("rst_quotient", int'(quotient), 0);
    check("rst_remainder", int'(remainder), 0);
    check("rst_dbz", int'(div_by_zero), 0);
    @(negedge ap_clk) ap_rst = 1'b0;
    @(posedge ap_clk); #1;

    do_op(100, 7, 14, 2, 1'b0);
    do_op(-100, 7, -14, -2, 1'b0);
    do_op(100, -7, -14, 2, 1'b0);
    do_op(-100, -7, 14, -2, 1'b0);
    do_op(-4096, 3, -1365, -1, 1'b0);
    do_op(-4096, -1, -4096, 0, 1'b0);
    do_op(-4096, -4096, 1, 0, 1'b0);
    do_op(4095, 4095, 1, 0, 1'b0);
    do_op(-1, 4095, 0, -1, 1'b0);
    do_op(0, 5, 0, 0, 1'b0);
`ifdef FACE_CLASSIFIER_SDIV_DBZ_SAT_EN
    do_op(5, 0, 4095, 0, 1'b1);
    do_op(-5, 0, -4096, 0, 1'b1);
    do_op(-4096, 0, -4096, 0, 1'b1);
`else
    do_op(5, 0, -1, 5, 1'b1);
    do_op(-5, 0, -1, -5, 1'b1);
    do_op(-4096, 0, -1, -4096, 1'b1);
`endif

    // Backpressure: result must hold and new operands must be ignored.
    dout_ready = 1'b0;
    do_op(50, 6, 8, 2, 1'b0);
    for (int i = 0; i < 20; i++) begin
      din_valid = 1'b1;
      dividend  = W'(9);
      divisor   = W'(3);
      @(posedge ap_clk); #1;
      check("bp_quotient", int'($signed(quotient)), 8);
      check("bp_remainder", int'($signed(remainder)), 2);
      check("bp_din_ready", int'(din_ready), 0);
      check("bp_dout_valid", int'(dout_valid), 1);
    end
    din_valid  = 1'b0;
    dout_ready = 1'b1;
    @(posedge ap_clk); #1;
    check("bp_release_din_ready", int'(din_ready), 1);
    check("bp_release_dout_valid", int'(dout_valid), 0);
    do_op(9, 3, 3, 0, 1'b0);

    // Asynchronous reset mid-division (count 6) aborts without presenting a result.
    start(100, 7);
    repeat (6) @(posedge ap_clk);
    #1;
    ap_rst = 1'b1;
    #1;
    check("abort_din_ready", int'(din_ready), 1);
    check("abort_dout_valid", int'(dout_valid), 0);
    check("abort_quotient", int'(quotient), 0);
    check("abort_remainder", int'(remainder), 0);
    check("abort_dbz", int'(div_by_zero), 0);
    @(negedge ap_clk) ap_rst = 1'b0;
    @(posedge ap_clk); #1;
    check("abort_no_result", int'(dout_valid), 0);
    do_op(77, 11, 7, 0, 1'b0);

    repeat (3) @(posedge ap_clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
